// File: rtl/blink_count_gen_pkg.sv
// Shared definitions for the blinker count generator.
//   WIDTH_DEF / DIV_WIDTH_DEF : default widths of count/mask and divider
//   DEFAULT_DIV / DEFAULT_MASK: values loaded into divider and mask at reset
//   state_e                   : config handshake FSM encoding
package blink_pkg;
  localparam int          WIDTH_DEF     = 16;
  localparam int          DIV_WIDTH_DEF = 16;
  localparam int          DEFAULT_DIV   = 1000;
  localparam logic [15:0] DEFAULT_MASK  = 16'h8000;

  typedef enum logic {
    S_IDLE = 1'b0,  // ready for a new config
    S_PEND = 1'b1   // config captured in shadow regs, waiting for a safe apply edge
  } state_e;
endpackage

// File: rtl/blink_count_gen_if.sv
// Config port of the blinker count generator (valid/ready).
//   cfg_valid : requester has a config word, held until accepted
//   cfg_ready : generator can accept a config word
//   cfg_div   : new divider, clk cycles per count step (0 acts as 1)
//   cfg_mask  : new mask
// master = requester side, slave = generator side.
interface blink_count_gen_if
  import blink_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0]     cfg_mask;

  modport master (output cfg_valid, cfg_div, cfg_mask, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_div, cfg_mask, output cfg_ready);
endinterface

// File: rtl/blink_count_gen_prescaler.sv
// Prescaler for the blinker count generator.
//   clk, rst  : clock, synchronous active-high reset
//   ena_i     : advance the divider counter; 0 freezes it
//   clr_i     : synchronous clear to 0 (wins over ena_i)
//   eff_div_i : effective divider, must be >= 1
//   step_o    : high in the cycle whose rising edge completes a period
module blink_prescaler
  import blink_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] eff_div_i,
  output logic                 step_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign step_o = ena_i && (cnt_q == eff_div_i - DIV_WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (ena_i) cnt_d = step_o ? '0 : cnt_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/blink_count_gen.sv
// Blinker count generator: free-running count plus active mask for the
// blinker's (count & mask) == mask comparison.
//   clk, rst  : clock, synchronous active-high reset
//   ena       : 1 = prescaler advances, 0 = hold
//   cfg       : config port (valid/ready, divider, mask), slave side
//   count_out : current count
//   mask_out  : active mask
//   tick      : pulse in the cycle count_out shows a new value
//   wrap      : pulse in the cycle count_out becomes 0 by overflow
// New config sits in shadow registers and is only applied on a count step
// edge (or any edge while held), so count/mask never appear torn.
module blink_count_gen
  import blink_pkg::*;
#(
  parameter int               WIDTH        = WIDTH_DEF,
  parameter int               DIV_WIDTH    = DIV_WIDTH_DEF,
  parameter int               DEFAULT_DIV  = blink_pkg::DEFAULT_DIV,
  parameter logic [WIDTH-1:0] DEFAULT_MASK = WIDTH'(blink_pkg::DEFAULT_MASK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  blink_count_gen_if.slave   cfg,
  output logic [WIDTH-1:0]   count_out,
  output logic [WIDTH-1:0]   mask_out,
  output logic               tick,
  output logic               wrap
);
  state_e               state_q;
  logic                 ready_q;
  logic [DIV_WIDTH-1:0] div_q, sh_div_q;
  logic [WIDTH-1:0]     count_q, mask_q, sh_mask_q;
  logic                 tick_q, wrap_q;

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 step;
  logic                 apply;

  // Divider 0 behaves as 1.
  assign eff_div = (div_q == '0) ? DIV_WIDTH'(1) : div_q;

  // Apply pending config on a step edge (old divider still times that step)
  // or on any held edge, where count cannot move.
  assign apply = (state_q == S_PEND) && (step || !ena);

  blink_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
    .clk       (clk),
    .rst       (rst),
    .ena_i     (ena),
    .clr_i     (apply),
    .eff_div_i (eff_div),
    .step_o    (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      div_q     <= DIV_WIDTH'(DEFAULT_DIV);
      mask_q    <= DEFAULT_MASK;
      sh_div_q  <= '0;
      sh_mask_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      tick_q <= step;
      wrap_q <= step && (count_q == '1);
      if (step) count_q <= count_q + WIDTH'(1);

      case (state_q)
        S_IDLE: if (cfg.cfg_valid && ready_q) begin
          sh_div_q  <= cfg.cfg_div;
          sh_mask_q <= cfg.cfg_mask;
          state_q   <= S_PEND;
          ready_q   <= 1'b0;
        end
        S_PEND: if (apply) begin
          div_q   <= sh_div_q;
          mask_q  <= sh_mask_q;
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign count_out     = count_q;
  assign mask_out      = mask_q;
  assign tick          = tick_q;
  assign wrap          = wrap_q;
endmodule

// File: tb/tb_blink_count_gen.sv
module tb_blink_count_gen;
  import blink_pkg::*;
  localparam int          W     = 16;
  localparam int          DW    = 16;
  localparam int          DDIV  = 4;
  localparam logic [15:0] DMASK = 16'h8000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [W-1:0]  count_out, mask_out;
  logic          tick, wrap;

  blink_count_gen_if #(.WIDTH(W), .DIV_WIDTH(DW)) cfg_if ();

  blink_count_gen #(.WIDTH(W), .DIV_WIDTH(DW), .DEFAULT_DIV(DDIV), .DEFAULT_MASK(DMASK)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg(cfg_if),
    .count_out(count_out), .mask_out(mask_out), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: absolute count, cycles elapsed in the current period,
  // live and pending config. Updated from the inputs seen at each rising edge.
  int          m_cnt, m_pre, m_div, m_sdiv, m_eff;
  logic [15:0] m_mask, m_smask;
  bit          m_tick, m_wrap, m_pend, m_hs, m_stp, m_app;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_div = DDIV; m_mask = DMASK;
      m_tick = 0; m_wrap = 0; m_pend = 0; m_hs = 0;
      chk_en = 1;
    end else begin
      m_eff  = (m_div == 0) ? 1 : m_div;
      m_stp  = ena && (m_pre == m_eff - 1);
      m_app  = m_pend && (m_stp || !ena);
      m_hs   = !m_pend && cfg_if.cfg_valid;
      m_tick = m_stp;
      m_wrap = m_stp && (m_cnt == 65535);
      if (m_stp) m_cnt = (m_cnt + 1) % 65536;
      if (ena)   m_pre = m_stp ? 0 : m_pre + 1;
      if (m_app) begin
        m_div = m_sdiv; m_mask = m_smask; m_pre = 0; m_pend = 0;
      end else if (m_hs) begin
        m_sdiv = cfg_if.cfg_div; m_smask = cfg_if.cfg_mask; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", count_out, m_cnt);
      chk("m_mask",  mask_out,  m_mask);
      chk("m_tick",  tick,      m_tick);
      chk("m_wrap",  wrap,      m_wrap);
      chk("m_ready", cfg_if.cfg_ready, !m_pend);
    end
  end

  // Hold valid until accepted; returns at the negedge after the handshake edge.
  task automatic do_cfg(input logic [15:0] d, input logic [15:0] m);
    bit ok = 0;
    cfg_if.cfg_div = d; cfg_if.cfg_mask = m; cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (cfg_if.cfg_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL cfg_handshake: ready never seen, got 0 expected 1");
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s: wait expired, got timeout expected event", nm);
  endtask

  int c0;
  bit found;

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0; cfg_if.cfg_mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst_count", count_out, 0);
    chk("rst_mask",  mask_out,  16'h8000);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_tick",  tick, 0);
    chk("rst_wrap",  wrap, 0);

    // 1: default divider 4
    ena = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i % 4 == 0) begin
        chk("t1_count", count_out, i / 4);
        chk("t1_tick",  tick, 1);
      end else chk("t1_notick", tick, 0);
    end
    chk("t1_mask", mask_out, 16'h8000);

    // 3: div 8 running, then mid-period reconfig to div 2 / mask 3
    do_cfg(16'd8, 16'h8000);
    repeat (20) @(negedge clk);
    found = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (tick) begin found = 1; break; end end
    if (!found) timeout("t3_tick");
    repeat (3) @(negedge clk);
    do_cfg(16'd2, 16'h0003);
    chk("t3_ready_low", cfg_if.cfg_ready, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mask_out == 16'h0003) begin found = 1; break; end
      chk("t3_ready_pend", cfg_if.cfg_ready, 0);
    end
    if (!found) timeout("t3_apply");
    chk("t3_apply_tick", tick, 1);
    chk("t3_ready_back", cfg_if.cfg_ready, 1);
    @(negedge clk); chk("t3_gap", tick, 0);
    @(negedge clk); chk("t3_next_tick", tick, 1);
    @(negedge clk); chk("t3_gap2", tick, 0);
    @(negedge clk); chk("t3_next_tick2", tick, 1);

    // 4: hold at prescaler 3 with div 8
    do_cfg(16'd8, 16'h8000);
    repeat (10) @(negedge clk);
    found = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (tick) begin found = 1; break; end end
    if (!found) timeout("t4_tick");
    repeat (3) @(negedge clk);
    ena = 1'b0; c0 = m_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_tick",  tick, 0);
      chk("t4_hold_count", count_out, c0);
    end
    ena = 1'b1;
    for (int i = 1; i <= 5; i++) begin @(negedge clk); chk("t4_resume_tick", tick, (i == 5)); end
    chk("t4_resume_count", count_out, (c0 + 1) % 65536);

    // 5: config while held applies on the next edge
    ena = 1'b0; c0 = m_cnt;
    do_cfg(16'd8, 16'h00F0);
    chk("t5_ready_pend", cfg_if.cfg_ready, 0);
    @(negedge clk);
    chk("t5_mask",  mask_out, 16'h00F0);
    chk("t5_ready", cfg_if.cfg_ready, 1);
    chk("t5_count", count_out, c0);

    // 2: divider 0 acts as 1, wrap at 16'hFFFF
    ena = 1'b1;
    do_cfg(16'd0, 16'h8000);
    found = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (count_out == 16'hFFFF) begin found = 1; break; end
    end
    if (!found) timeout("t2_top");
    @(negedge clk);
    chk("t2_wrap_count", count_out, 0);
    chk("t2_wrap",       wrap, 1);
    chk("t2_wrap_tick",  tick, 1);
    @(negedge clk);
    chk("t2_wrap_clear", wrap, 0);
    chk("t2_count1",     count_out, 1);
    chk("t2_tick1",      tick, 1);

    // 6: reset while pending at count 37
    do_cfg(16'd20, 16'h8000);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (count_out == 16'd37) begin found = 1; break; end
    end
    if (!found) timeout("t6_count37");
    do_cfg(16'd5, 16'h1234);
    chk("t6_pending",  cfg_if.cfg_ready, 0);
    chk("t6_count37",  count_out, 37);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_count", count_out, 0);
    chk("t6_rst_mask",  mask_out, 16'h8000);
    chk("t6_rst_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("t6_no_apply", mask_out, 16'h8000);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if (cfg_if.cfg_valid && m_hs) cfg_if.cfg_valid = 1'b0;
      else if (!cfg_if.cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_if.cfg_div   = 16'($urandom_range(0, 6));
        cfg_if.cfg_mask  = 16'($urandom_range(0, 65535));
        cfg_if.cfg_valid = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
